// File: rtl/alarm_pkg.sv
// Alarm unit shared types and constants.
// State encoding and time-field wrap limits.
package alarm_pkg;

  localparam int TW = 6;

  localparam logic [TW-1:0] MIN_MAX = 6'd59;
  localparam logic [TW-1:0] HR_MAX  = 6'd23;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE
  } state_t;

endpackage

// File: rtl/alarm_if.sv
// Alarm unit bus: time inputs, controls and
// alarm status outputs.
interface alarm_if;
  import alarm_pkg::*;

  logic          i_tick_1hz;
  logic [TW-1:0] i_sec;
  logic [TW-1:0] i_min;
  logic [TW-1:0] i_hr;
  logic          i_alarm_en;
  logic          i_set_en;
  logic          i_set_pos;
  logic          i_inc;
  logic          i_stop;
  logic          i_snooze;
  logic [TW-1:0] o_alarm_min;
  logic [TW-1:0] o_alarm_hr;
  logic          o_ringing;
  logic          o_snoozing;
  logic          o_buzz;

  modport master (
    output i_tick_1hz, i_sec, i_min, i_hr,
    output i_alarm_en, i_set_en, i_set_pos,
    output i_inc, i_stop, i_snooze,
    input  o_alarm_min, o_alarm_hr,
    input  o_ringing, o_snoozing, o_buzz
  );

  modport slave (
    input  i_tick_1hz, i_sec, i_min, i_hr,
    input  i_alarm_en, i_set_en, i_set_pos,
    input  i_inc, i_stop, i_snooze,
    output o_alarm_min, o_alarm_hr,
    output o_ringing, o_snoozing, o_buzz
  );

endinterface

// File: rtl/beep_gen.sv
// Square-wave beep generator; starts high on
// restart, toggles every BEEP_HALF cycles.
module beep_gen #(
  parameter int BEEP_HALF = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic wave
);

  localparam logic [31:0] HALF_LAST =
    32'(BEEP_HALF - 1);

  logic [31:0] cnt;

  // Phase counter and output; held low when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      wave <= 1'b1;
    end else if (!enable) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (cnt == HALF_LAST) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt  <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm-time edit, match
// trigger, ring/snooze FSM and buzzer gating.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int BEEP_HALF  = 12_500_000
) (
  input  logic    clk,
  input  logic    rst,
  alarm_if.slave  bus
);

  localparam logic [7:0]  RING_LAST =
    8'(RING_SEC - 1);
  localparam logic [11:0] SNZ_LOAD  =
    12'(SNOOZE_MIN * 60);

  state_t        state;
  state_t        state_d;
  logic [7:0]    ring_cnt;
  logic [11:0]   snz_cnt;
  logic [TW-1:0] al_min;
  logic [TW-1:0] al_hr;
  logic          ringing;
  logic          snoozing;
  logic          buzz;
  logic          tick;
  logic          match;
  logic          ring_d;
  logic          ring_start;

  assign tick  = bus.i_tick_1hz;
  assign match = tick
              && bus.i_hr  == al_hr
              && bus.i_min == al_min
              && bus.i_sec == '0;

  // Next state with enable > stop > snooze > tick priority.
  always_comb begin
    state_d = state;
    if (!bus.i_alarm_en) begin
      state_d = IDLE;
    end else if (bus.i_stop) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (match) state_d = RING;
        end
        RING: begin
          if (bus.i_snooze)
            state_d = SNOOZE;
          else if (tick && ring_cnt == RING_LAST)
            state_d = IDLE;
        end
        SNOOZE: begin
          if (tick && snz_cnt == 12'd1)
            state_d = RING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ring_d     = (state_d == RING);
  assign ring_start = ring_d && (state != RING);

  // FSM state, ring/snooze counters, status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      state    <= state_d;
      ringing  <= ring_d;
      snoozing <= (state_d == SNOOZE);
      if (ring_start)
        ring_cnt <= '0;
      else if (state == RING && tick)
        ring_cnt <= ring_cnt + 8'd1;
      if (state == RING && state_d == SNOOZE)
        snz_cnt <= SNZ_LOAD;
      else if (state == SNOOZE && tick)
        snz_cnt <= snz_cnt - 12'd1;
    end
  end

  // Alarm-time edit; fields wrap without carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al_min <= '0;
      al_hr  <= '0;
    end else if (bus.i_set_en && bus.i_inc) begin
      if (bus.i_set_pos)
        al_hr  <= (al_hr == HR_MAX)
                ? '0 : al_hr + 6'd1;
      else
        al_min <= (al_min == MIN_MAX)
                ? '0 : al_min + 6'd1;
    end
  end

  beep_gen #(
    .BEEP_HALF (BEEP_HALF)
  ) u_beep (
    .clk     (clk),
    .rst     (rst),
    .enable  (ring_d),
    .restart (ring_start),
    .wave    (buzz)
  );

  assign bus.o_alarm_min = al_min;
  assign bus.o_alarm_hr  = al_hr;
  assign bus.o_ringing   = ringing;
  assign bus.o_snoozing  = snoozing;
  assign bus.o_buzz      = buzz;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl: vector table plus
// hand sequences, checked through a queue.
module tb_alarm_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alarm_if bus ();

  alarm_ctrl #(
    .RING_SEC   (3),
    .SNOOZE_MIN (1),
    .BEEP_HALF  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      nm;
    logic       en;
    logic       set_en;
    logic       set_pos;
    logic       inc;
    logic       stop;
    logic       snz;
    logic       tick;
    logic [5:0] hr;
    logic [5:0] mn;
    logic [5:0] sec;
    logic       r;
    logic       s;
    logic       b;
    logic [5:0] ahr;
    logic [5:0] amin;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(string nm,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d",
               nm, got, exp);
    end
  endtask

  function automatic vec_t mk(
    string nm, logic en, logic tick,
    logic [5:0] hr, logic [5:0] mn,
    logic [5:0] sec, logic stop, logic snz,
    logic r, logic s, logic b);
    vec_t v;
    v.nm = nm;       v.en = en;
    v.set_en = 0;    v.set_pos = 0;
    v.inc = 0;       v.stop = stop;
    v.snz = snz;     v.tick = tick;
    v.hr = hr;       v.mn = mn;
    v.sec = sec;     v.r = r;
    v.s = s;         v.b = b;
    v.ahr = 6'd7;    v.amin = 6'd30;
    return v;
  endfunction

  function automatic vec_t ed(
    string nm, logic pos,
    logic [5:0] ahr, logic [5:0] amin);
    vec_t v;
    v = mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.set_en = 1;  v.set_pos = pos;
    v.inc = 1;     v.ahr = ahr;
    v.amin = amin;
    return v;
  endfunction

  task automatic apply(vec_t v);
    vec_t e;
    @(negedge clk);
    bus.i_alarm_en = v.en;
    bus.i_set_en   = v.set_en;
    bus.i_set_pos  = v.set_pos;
    bus.i_inc      = v.inc;
    bus.i_stop     = v.stop;
    bus.i_snooze   = v.snz;
    bus.i_tick_1hz = v.tick;
    bus.i_hr       = v.hr;
    bus.i_min      = v.mn;
    bus.i_sec      = v.sec;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.nm, ".ring"}, 32'(bus.o_ringing), 32'(e.r));
    chk({e.nm, ".snz"}, 32'(bus.o_snoozing), 32'(e.s));
    chk({e.nm, ".buzz"}, 32'(bus.o_buzz), 32'(e.b));
    chk({e.nm, ".ahr"}, 32'(bus.o_alarm_hr), 32'(e.ahr));
    chk({e.nm, ".amin"}, 32'(bus.o_alarm_min), 32'(e.amin));
  endtask

  // trigger at 07:30:00 with the default alarm
  function automatic vec_t trig(string nm);
    return mk(nm, 1, 1, 7, 30, 0, 0, 0, 1, 0, 1);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.i_alarm_en = 0; bus.i_set_en = 0;
    bus.i_set_pos = 0;  bus.i_inc = 0;
    bus.i_stop = 0;     bus.i_snooze = 0;
    bus.i_tick_1hz = 0; bus.i_hr = 0;
    bus.i_min = 0;      bus.i_sec = 0;
    #1;
    chk("rst.ring", 32'(bus.o_ringing), 0);
    chk("rst.snz", 32'(bus.o_snoozing), 0);
    chk("rst.buzz", 32'(bus.o_buzz), 0);
    chk("rst.ahr", 32'(bus.o_alarm_hr), 0);
    chk("rst.amin", 32'(bus.o_alarm_min), 0);
    @(negedge clk);
    rst = 1'b0;

    // edit wrap
    for (int i = 0; i < 24; i++)
      apply(ed($sformatf("hr%0d", i), 1,
               6'((i + 1) % 24), 0));
    for (int i = 0; i < 61; i++)
      apply(ed($sformatf("mn%0d", i), 0,
               0, 6'((i + 1) % 60)));
    v = ed("inc_noset", 0, 0, 1);
    v.set_en = 0;
    apply(v);
    for (int i = 0; i < 7; i++)
      apply(ed("hr_to7", 1, 6'(i + 1), 1));
    for (int i = 0; i < 29; i++)
      apply(ed("mn_to30", 0, 7, 6'(i + 2)));

    // trigger, beep pattern, timeout
    tbl.push_back(mk("sec1", 1, 1, 7, 30, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("notick", 1, 0, 7, 30, 0, 0, 0, 0, 0, 0));
    tbl.push_back(trig("trig"));
    tbl.push_back(mk("bp2", 1, 0, 7, 30, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk("bp3", 1, 0, 7, 30, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk("bp4", 1, 0, 7, 30, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk("bp5", 1, 0, 7, 30, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("bp6", 1, 0, 7, 30, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("bp7", 1, 0, 7, 30, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("bp8", 1, 0, 7, 30, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("bp9", 1, 0, 7, 30, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk("to1", 1, 1, 7, 30, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk("to2", 1, 1, 7, 30, 2, 0, 0, 1, 0, 1));
    tbl.push_back(mk("to3", 1, 1, 7, 30, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk("to4", 1, 1, 7, 30, 4, 0, 0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // snooze, 60-tick return, ring counter reload
    apply(trig("s_trig"));
    apply(mk("s_go", 1, 0, 8, 0, 0, 0, 1, 0, 1, 0));
    apply(mk("s_ign", 1, 0, 8, 0, 0, 0, 1, 0, 1, 0));
    for (int i = 0; i < 59; i++)
      apply(mk($sformatf("s_t%0d", i + 1), 1, 1,
               8, 0, 6'(i % 60), 0, 0, 0, 1, 0));
    apply(mk("s_t60", 1, 1, 8, 1, 0, 0, 0, 1, 0, 1));
    apply(mk("s_r1", 1, 1, 8, 1, 1, 0, 0, 1, 0, 1));
    apply(mk("s_r2", 1, 1, 8, 1, 2, 0, 0, 1, 0, 1));
    apply(mk("s_r3", 1, 1, 8, 1, 3, 0, 0, 0, 0, 0));
    apply(trig("s2_trig"));
    apply(mk("s2_go", 1, 0, 8, 0, 0, 0, 1, 0, 1, 0));
    apply(mk("s2_stop", 1, 0, 8, 0, 0, 1, 0, 0, 0, 0));

    // priority
    apply(trig("p_trig"));
    apply(mk("p_both", 1, 0, 8, 0, 0, 1, 1, 0, 0, 0));
    apply(trig("p_trig2"));
    apply(mk("p_endrop", 0, 0, 8, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("p_dis", 0, 1, 7, 30, 0, 0, 0, 0, 0, 0));
    apply(mk("p_idle", 1, 0, 7, 30, 0, 0, 0, 0, 0, 0));

    // edit while ringing keeps the state
    apply(trig("e_trig"));
    v = mk("e_inc", 1, 0, 7, 30, 0, 0, 0, 1, 0, 1);
    v.set_en = 1; v.set_pos = 1; v.inc = 1;
    v.ahr = 8;
    apply(v);

    // asynchronous reset mid-ring
    v = mk("r_trig", 1, 1, 8, 30, 0, 0, 0, 1, 0, 1);
    v.ahr = 8;
    apply(v);
    bus.i_tick_1hz = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar.ring", 32'(bus.o_ringing), 0);
    chk("ar.snz", 32'(bus.o_snoozing), 0);
    chk("ar.buzz", 32'(bus.o_buzz), 0);
    chk("ar.ahr", 32'(bus.o_alarm_hr), 0);
    chk("ar.amin", 32'(bus.o_alarm_min), 0);
    @(negedge clk);
    rst = 1'b0;
    v = mk("ar_idle", 1, 0, 8, 30, 0, 0, 0, 0, 0, 0);
    v.ahr = 0; v.amin = 0;
    apply(v);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm unit that sits directly downstream of the hour/minute/second counters. It holds a user-set alarm time (hour:minute) and compares it against the running time once per second. On a match it rings for a bounded time, and supports stop and snooze. It drives a gated beep output toward the buzzer pin, and exports the alarm time for the display path.

## Interface
Parameters:
- `RING_SEC`, default 60: ring duration in seconds. Legal range 1..255.
- `SNOOZE_MIN`, default 5: snooze duration in minutes. Legal range 1..60.
- `BEEP_HALF`, default 12_500_000: clk cycles per beep half-period (2 Hz at 50 MHz). Must be ≥1.

Ports:
- `clk`, in, 1: system clock (50 MHz).
- `rst`, in, 1: reset, asynchronous, active-high.
- `i_tick_1hz`, in, 1: single-cycle pulse, once per second, synchronous to clk.
- `i_sec`, in, 6: current seconds, 0..59.
- `i_min`, in, 6: current minutes, 0..59.
- `i_hr`, in, 6: current hours, 0..23.
- `i_alarm_en`, in, 1: level; alarm armed when 1.
- `i_set_en`, in, 1: level; alarm-time edit mode.
- `i_set_pos`, in, 1: field to edit; 0 = minute, 1 = hour.
- `i_inc`, in, 1: single-cycle pulse; increment the selected alarm field.
- `i_stop`, in, 1: single-cycle pulse; stop ringing or snooze.
- `i_snooze`, in, 1: single-cycle pulse; snooze while ringing.
- `o_alarm_min`, out, 6: stored alarm minute.
- `o_alarm_hr`, out, 6: stored alarm hour.
- `o_ringing`, out, 1: 1 while in state RING.
- `o_snoozing`, out, 1: 1 while in state SNOOZE.
- `o_buzz`, out, 1: gated beep output toward the buzzer.

## Operation
Alarm time edit:
- An increment happens only when `i_set_en`=1 and `i_inc`=1.
- Minute field wraps 59→0. Hour field wraps 23→0. There is no carry between fields.
- Editing is allowed in any FSM state and does not change the state.

FSM states: IDLE, RING, SNOOZE.

IDLE → RING when all of the following hold in the same cycle:
- `i_tick_1hz`=1;
- `i_alarm_en`=1;
- `i_hr`==`o_alarm_hr` and `i_min`==`o_alarm_min`;
- `i_sec`==0.

The time inputs are the values present in the tick cycle. An edit in the same cycle does not affect the compare, which uses the pre-edit registers.

RING:
- A ring counter loads 0 on entry and increments on each tick.
- `i_stop` → IDLE.
- `i_snooze` → SNOOZE; the snooze counter loads SNOOZE_MIN*60.
- Ring counter reaches RING_SEC−1 and a tick arrives → IDLE (timeout).

SNOOZE:
- Each tick decrements the snooze counter.
- Counter at 1 and a tick arrives → RING; the ring counter reloads 0.
- `i_stop` → IDLE.
- `i_snooze` is ignored.

Priority, highest first:
1. `i_alarm_en`=0 (any state → IDLE).
2. `i_stop`.
3. `i_snooze`.
4. Tick-driven transitions.

A match tick while already in RING or SNOOZE causes no retrigger.

Beep generation:
- Applies in RING only. `o_buzz` starts at 1 on RING entry.
- `o_buzz` toggles every BEEP_HALF clk cycles.
- `o_buzz`=0 in IDLE and SNOOZE.
- The beep phase counter clears on every RING entry.

Counter widths:
- Ring counter: 8 bits.
- Snooze counter: 12 bits (max 3600).
- Beep counter: 32 bits.
- All compares are unsigned.

## Timing
Reset values:
- State = IDLE.
- `o_alarm_min` = 0, `o_alarm_hr` = 0.
- `o_ringing` = 0, `o_snoozing` = 0, `o_buzz` = 0.
- All counters = 0.

Latencies:
- Trigger tick at edge N → `o_ringing`=1 and `o_buzz`=1 after edge N+1 (registered, 1-cycle latency).
- `i_stop`, `i_snooze` or `i_alarm_en` falling → state outputs update 1 cycle later.
- `i_inc` → alarm field output updates 1 cycle later.

Beep:
- First `o_buzz` toggle occurs BEEP_HALF cycles after RING entry.

Reset mid-ring:
- `rst` asserted mid-RING forces all outputs to 0 asynchronously.
- The stored alarm time is lost.

## Structure
- Shared package `alarm_pkg` holds:
  - the state enum (IDLE/RING/SNOOZE);
  - the time-field width constant (6);
  - the wrap constants MIN_MAX=59 and HR_MAX=23.
- One sub-module, `beep_gen`:
  - inputs: clk, rst, enable, restart;
  - output: square wave;
  - parameter: BEEP_HALF.
- Everything else lives in `alarm_ctrl`.

## Test plan
Use RING_SEC=3, SNOOZE_MIN=1 and BEEP_HALF=4 unless noted.

1. Edit wrap: set_pos=1 with 24 `i_inc` pulses → `o_alarm_hr` goes 0..23 then back to 0. set_pos=0 with 61 pulses → `o_alarm_min`=1.
2. Trigger: alarm 07:30, drive the tick with time 07:30:00 → `o_ringing`=1 one cycle later, `o_buzz` pattern 1111 0000 repeating. Time 07:30:01 produces no trigger.
3. Timeout: after the trigger, 3 ticks → `o_ringing` falls after the 3rd tick. A 4th tick at a non-matching time keeps the block in IDLE.
4. Snooze: `i_snooze` in RING → `o_snoozing`=1, `o_buzz`=0. The 60th tick returns to RING. `i_stop` in SNOOZE → IDLE.
5. Priority: `i_stop` and `i_snooze` in the same cycle → IDLE. Dropping `i_alarm_en` in RING → IDLE. A matching tick with `i_alarm_en`=0 → no ring.
6. Reset: assert `rst` mid-RING between clk edges → all outputs are 0 immediately and the alarm time reads 00:00.
